// File: rtl/signal_field_sweeper.sv
// signal_field_sweeper: streams a GRID_W x GRID_H signal field out of a
// synchronous RAM, one cell per cycle. Two line buffers and a 3x3 window
// produce each cell's neighbourhood. The next generation (own value halved,
// plus an eighth of each neighbour, plus the ant deposit) goes to a second RAM.
// Optional build macro: SIGNAL_SATURATE_EN clamps the result instead of wrapping it.
module signal_field_sweeper #(
  parameter int GRID_W               = 16,
  parameter int GRID_H               = 16,
  parameter int SIGNAL_bits          = 16,
  parameter int ANT_num              = 4,
  parameter int ANT_SIGNAL_SPEW_RATE = 16,
  parameter int ADDR_W               = $clog2(GRID_W * GRID_H)
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     start,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     rd_en,
  output logic [ADDR_W-1:0]                        rd_addr,
  input  logic [SIGNAL_bits-1:0]                   rd_data,
  output logic                                     wr_en,
  output logic [ADDR_W-1:0]                        wr_addr,
  output logic [SIGNAL_bits-1:0]                   wr_data,
  input  logic [ANT_num-1:0][$clog2(GRID_W)-1:0]   ant_x,
  input  logic [ANT_num-1:0][$clog2(GRID_H)-1:0]   ant_y,
  input  logic [ANT_num-1:0]                       ant_spew
);

  localparam int N      = GRID_W * GRID_H;
  localparam int XW     = $clog2(GRID_W);
  localparam int YW     = $clog2(GRID_H);
  localparam int TICK_W = $clog2(N + GRID_W + 8);
  localparam int CW     = $clog2(ANT_num + 1);

  // The saturating build keeps the full-width intermediate so that it can detect
  // overflow. The wrapping build keeps only the low bits, because carries above
  // bit SIGNAL_bits-1 never reach the wrapped result.
`ifdef SIGNAL_SATURATE_EN
  localparam int SUM_W = SIGNAL_bits + $clog2(ANT_num) + 8;
  localparam logic [SUM_W-1:0] SAT_LIMIT = {{(SUM_W - SIGNAL_bits){1'b0}}, {SIGNAL_bits{1'b1}}};
`else
  localparam int SUM_W = SIGNAL_bits;
`endif

  // Tick values that mark the sweep phases. tick counts from 0 in the first SWEEP cycle.
  localparam logic [TICK_W-1:0] LAST_READ  = TICK_W'(N - 1);
  localparam logic [TICK_W-1:0] CALC_FIRST = TICK_W'(GRID_W + 2);
  localparam logic [TICK_W-1:0] CALC_LAST  = TICK_W'(N + GRID_W + 1);
  localparam logic [TICK_W-1:0] DRAIN_LAST = TICK_W'(N + GRID_W + 2);
  localparam logic [XW-1:0]     X_LAST     = XW'(GRID_W - 1);
  localparam logic [YW-1:0]     Y_LAST     = YW'(GRID_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } stateT;

  stateT                     state;
  stateT                     stateNext;
  logic                      accept;
  logic                      running;
  logic [TICK_W-1:0]         tick;
  logic                      rdValid;
  logic [SIGNAL_bits-1:0]    shiftIn;
  logic                      calcValid;

  logic [SIGNAL_bits-1:0]    lineA   [GRID_W];
  logic [SIGNAL_bits-1:0]    lineB   [GRID_W];
  logic [SIGNAL_bits-1:0]    winMid  [3];
  logic [SIGNAL_bits-1:0]    winLeft [3];

  logic [XW-1:0]             outX;
  logic [YW-1:0]             outY;
  logic [ADDR_W-1:0]         outAddr;

  logic [ANT_num-1:0][XW-1:0] antXq;
  logic [ANT_num-1:0][YW-1:0] antYq;
  logic [ANT_num-1:0]         antSpewq;

  logic                      hasL, hasR, hasU, hasD;
  logic [SIGNAL_bits-1:0]    cur;
  logic [SIGNAL_bits-1:0]    nbrVal [8];
  logic                      nbrOk  [8];
  logic [CW-1:0]             spewCnt;
  logic [SUM_W-1:0]          sum;
  logic [SIGNAL_bits-1:0]    newVal;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Next-state logic and control strobes that follow directly from the state.
  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    accept    = 1'b0;
    running   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = SWEEP;
          accept    = 1'b1;
        end
      end
      SWEEP: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        running = 1'b1;
        if (tick == LAST_READ) stateNext = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        running = 1'b1;
        if (tick == DRAIN_LAST) stateNext = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign rd_addr   = rd_en ? tick[ADDR_W-1:0] : '0;
  assign shiftIn   = rdValid ? rd_data : '0;
  assign calcValid = running && (tick >= CALC_FIRST) && (tick <= CALC_LAST);

  // Sweep cycle counter. It also serves as the read address during SWEEP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     tick <= '0;
    else if (running) tick <= tick + TICK_W'(1);
    else              tick <= '0;
  end

  // Marks the cycle in which the RAM returns data for the previous read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdValid <= 1'b0;
    else          rdValid <= rd_en;
  end

  // Line buffers plus the left and middle window columns shift once per active
  // cycle. Stale samples from the previous row or sweep only fall in
  // out-of-grid positions, and those positions are masked by coordinate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < GRID_W; i++) begin
        lineA[i] <= '0;
        lineB[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        winMid[r]  <= '0;
        winLeft[r] <= '0;
      end
    end else if (running) begin
      lineA[0] <= shiftIn;
      lineB[0] <= lineA[GRID_W-1];
      for (int i = 1; i < GRID_W; i++) begin
        lineA[i] <= lineA[i-1];
        lineB[i] <= lineB[i-1];
      end
      winMid[2] <= shiftIn;
      winMid[1] <= lineA[GRID_W-1];
      winMid[0] <= lineB[GRID_W-1];
      for (int r = 0; r < 3; r++) winLeft[r] <= winMid[r];
    end
  end

  // Raster position of the cell being computed. It advances once per computed cell.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outX    <= '0;
      outY    <= '0;
      outAddr <= '0;
    end else if (accept) begin
      outX    <= '0;
      outY    <= '0;
      outAddr <= '0;
    end else if (calcValid) begin
      if (outX == X_LAST) begin
        outX <= '0;
        outY <= outY + YW'(1);
      end else begin
        outX <= outX + XW'(1);
      end
      outAddr <= outAddr + ADDR_W'(1);
    end
  end

  // Ant positions are captured once when a sweep is accepted and held for the whole sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      antXq    <= '0;
      antYq    <= '0;
      antSpewq <= '0;
    end else if (accept) begin
      antXq    <= ant_x;
      antYq    <= ant_y;
      antSpewq <= ant_spew;
    end
  end

  // New value for the current cell. The right window column is taken live from
  // the buffer taps and the incoming read data, so the result is ready one cycle
  // before the write.
  always_comb begin
    hasL = (outX != '0);
    hasR = (outX != X_LAST);
    hasU = (outY != '0);
    hasD = (outY != Y_LAST);
    cur  = winMid[1];

    nbrVal[0] = winLeft[0];        nbrOk[0] = hasU && hasL;
    nbrVal[1] = winMid[0];         nbrOk[1] = hasU;
    nbrVal[2] = lineB[GRID_W-1];   nbrOk[2] = hasU && hasR;
    nbrVal[3] = winLeft[1];        nbrOk[3] = hasL;
    nbrVal[4] = lineA[GRID_W-1];   nbrOk[4] = hasR;
    nbrVal[5] = winLeft[2];        nbrOk[5] = hasD && hasL;
    nbrVal[6] = winMid[2];         nbrOk[6] = hasD;
    nbrVal[7] = shiftIn;           nbrOk[7] = hasD && hasR;

    sum = SUM_W'(cur >> 1);
    for (int d = 0; d < 8; d++) begin
      if (nbrOk[d]) sum = sum + SUM_W'(nbrVal[d] >> 3);
      else          sum = sum + SUM_W'(cur >> 3);
    end

    spewCnt = '0;
    for (int i = 0; i < ANT_num; i++) begin
      if (antSpewq[i] && (antXq[i] == outX) && (antYq[i] == outY)) spewCnt = spewCnt + CW'(1);
    end
    sum = sum + SUM_W'(spewCnt) * SUM_W'(ANT_SIGNAL_SPEW_RATE);

`ifdef SIGNAL_SATURATE_EN
    if (sum > SAT_LIMIT) newVal = '1;
    else                 newVal = sum[SIGNAL_bits-1:0];
`else
    newVal = sum;
`endif
  end

  // Registered write port to the next-field RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= calcValid;
      if (calcValid) begin
        wr_addr <= outAddr;
        wr_data <= newVal;
      end
    end
  end

endmodule

// File: doc/signal_field_sweeper.md
# signal_field_sweeper

Sequential, parametrised successor to the per-cell pheromone update. It sweeps an entire GRID_W x GRID_H signal field stored in an external synchronous RAM and writes the next-generation field to a second RAM, one cell per cycle. Each new value is the cell's own signal halved, plus one eighth of each of its 8 neighbours, plus the ant deposit on that cell. A 2-line buffer plus a 3x3 window replaces per-cell neighbour wiring; the block sits between the field double-buffer and the ant controller.

## Interface
- GRID_W, 16: field width in cells; minimum 3.
- GRID_H, 16: field height in cells; minimum 3.
- SIGNAL_bits, 16: width of one signal value.
- ANT_num, 4: number of ants.
- ANT_SIGNAL_SPEW_RATE, 16: signal added per spewing ant on a cell.
- ADDR_W, $clog2(GRID_W*GRID_H): RAM address width.

- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin one sweep; accepted only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the done cycle.
- done  out  1  one-cycle pulse when the last cell has been written.
- rd_en  out  1  read strobe to the current-field RAM.
- rd_addr  out  ADDR_W  raster address, y*GRID_W+x.
- rd_data  in  SIGNAL_bits  current-field data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  write strobe to the next-field RAM.
- wr_addr  out  ADDR_W  cell being written.
- wr_data  out  SIGNAL_bits  new signal value.
- ant_x  in  [ANT_num][$clog2(GRID_W)]  ant column.
- ant_y  in  [ANT_num][$clog2(GRID_H)]  ant row.
- ant_spew  in  ANT_num  ant is updating with a full mouth.

## Operation
- States:
  - IDLE: start=1 latches ant_x, ant_y and ant_spew, then goes to SWEEP.
  - SWEEP: issues reads 0..N-1 with N = GRID_W*GRID_H, one per cycle, then goes to DRAIN.
  - DRAIN: no reads; the pipeline flushes the remaining writes, then goes to DONE.
  - DONE: one cycle, done=1, then returns to IDLE.
- start during any state other than IDLE is ignored. Ant inputs are sampled only at acceptance.
- Returned data shifts into two GRID_W-deep line buffers and a 3x3 register window. Cell (x,y) is computed once (x+1,y+1) has arrived; the last row and last column are computed while read data is absent.
- Neighbour rule: a neighbour outside the grid contributes cur>>3 in place of its own value.
- Arithmetic:
  - Each term is shifted before summing: new = (cur>>1) + sum over d of (n_d>>3) + cnt*ANT_SIGNAL_SPEW_RATE.
  - cnt is the number of latched ants with ant_spew=1 at exactly (x,y).
  - Intermediate width is SIGNAL_bits+$clog2(ANT_num)+8, so the sum never overflows before the final resize.
- Ants with coordinates outside the grid contribute nothing.
- Writes occur in strictly ascending raster order, exactly N writes per sweep.

## Timing
- Cycle 0 is the cycle in which start is sampled high in IDLE.
- Reads: rd_addr=k with rd_en=1 on cycle k+1, for k in 0..N-1. rd_data for k is sampled on cycle k+2.
- Writes: wr_en=1 with wr_addr=k on cycle k+GRID_W+4.
- done=1 on cycle N+GRID_W+4; busy falls the cycle after done.
- Total sweep time is N+GRID_W+5 cycles including the return to IDLE. A new start is accepted on that cycle.
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0; state=IDLE; line buffers, window and latched ant data are cleared.
- Assertion of reset_n mid-sweep immediately drops rd_en and wr_en, with no partial done. Any partially written next field is undefined and must be re-swept.

## Configuration
- SIGNAL_SATURATE_EN:
  - Defined: the final value clamps to 2^SIGNAL_bits-1 when the intermediate sum exceeds it.
  - Undefined: the final value is the low SIGNAL_bits of the sum (wrap-around, matching the legacy per-cell behaviour).

## Test plan
- 3x3 grid, SIGNAL_bits=8, all cells 64, no ants -> all 9 writes = 96; done on cycle 9+3+4=16.
- 3x3 grid, centre=80 and all others 0, no ants -> centre written 40, each of the other 8 cells 10.
- Zero 4x4 field, two ants at (1,1) with spew=1 and one at (1,1) with spew=0, SPEW_RATE=16 -> wr_addr 5 = 32, all other cells 0. Changing ant inputs mid-sweep has no effect.
- 3x3 grid, SIGNAL_bits=8, all cells 255 -> 255 everywhere with SIGNAL_SATURATE_EN; 375 mod 256 = 119 everywhere without it.
- start pulsed again during SWEEP -> ignored, exactly N writes. reset_n low at cycle 6 -> rd_en, wr_en and busy are 0 in the same cycle and no done; a fresh start completes normally.
- 16x16 random field, back-to-back sweeps with start held high -> writes match the reference model bit-exactly in raster order. The second sweep's reads begin the cycle after the first sweep returns to IDLE.
